// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, decode payload
// struct, reset PC / NOP values and the compressed-instruction length decode.
package fetch_pc_sequencer_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h8000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FLUSH = 2'd0,
    FILL0 = 2'd1,
    FILL1 = 2'd2,
    RUN   = 2'd3
  } type_fetch_state_e;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic            is_comp;
    logic            valid;
  } type_fetch2dec_s;

  // A halfword whose two low bits are not 2'b11 starts a 16-bit instruction.
  function automatic logic head_is_comp(input logic [15:0] head);
    return head[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_pc_sequencer_if.sv
// Prefetch-side and decode-side signal bundle of the fetch PC sequencer.
// master = the sequencer, slave = its environment (prefetch, decode, EX/CSR).
interface fetch_pc_sequencer_if #(
  parameter int XLEN = 32
);
  logic            redirect_valid_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic [15:0]     pref_head_i;
  logic            pref_ack_i;
  logic [31:0]     pref_instr_i;
  logic [XLEN-1:0] pref_pc_o;
  logic            pref_instr_req_o;
  logic            pref_misalign_o;
  logic            pref_is_comp_o;
  logic            pref_clear_o;
  logic            dec_valid_o;
  logic            dec_ready_i;
  logic [31:0]     dec_instr_o;
  logic [XLEN-1:0] dec_pc_o;
  logic            dec_is_comp_o;

  modport master (
    input  redirect_valid_i, redirect_pc_i, pref_head_i, pref_ack_i, pref_instr_i, dec_ready_i,
    output pref_pc_o, pref_instr_req_o, pref_misalign_o, pref_is_comp_o, pref_clear_o,
    output dec_valid_o, dec_instr_o, dec_pc_o, dec_is_comp_o
  );

  modport slave (
    output redirect_valid_i, redirect_pc_i, pref_head_i, pref_ack_i, pref_instr_i, dec_ready_i,
    input  pref_pc_o, pref_instr_req_o, pref_misalign_o, pref_is_comp_o, pref_clear_o,
    input  dec_valid_o, dec_instr_o, dec_pc_o, dec_is_comp_o
  );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry valid/ready register slice with a generic payload type and a
// synchronous flush that drops the held entry.
module fetch_skid_buf #(
  parameter type T         = logic [31:0],
  parameter T    RESET_VAL = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic in_valid,
  input  T     in_data,
  output logic in_ready,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic full;
  T     data;

  // NOTE: registers take non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours, independent of block ordering.
  // NOTE: the payload is reset too (not just the valid bit) because decode
  // sees its pc field as dec_pc_o straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full <= 1'b0;
      data <= RESET_VAL;
    end else if (flush) begin
      full <= 1'b0;
    end else if (in_valid) begin
      full <= 1'b1;
      data <= in_data;
    end else if (out_ready) begin
      full <= 1'b0;
    end
  end

  // A new entry may land when empty, or when the current one leaves this cycle.
  assign in_ready  = !full || out_ready;
  assign out_valid = full;
  assign out_data  = data;

endmodule

// File: rtl/fetch_pc_sequencer.sv
// IF-stage PC owner between the prefetch FIFO and decode. Compressed (16-bit)
// instruction support is compiled in only when FETCH_COMP_EN is defined.
module fetch_pc_sequencer #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h8000_0000,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input logic                 clk,
  input logic                 reset,
  fetch_pc_sequencer_if.master bus
);
  import fetch_pc_sequencer_pkg::*;

  localparam type_fetch2dec_s SKID_RESET = '{
    instr: NOP_INSTR, pc: RESET_PC, is_comp: 1'b0, valid: 1'b0
  };

  type_fetch_state_e state;
  logic [XLEN-1:0]   pc_ff;
  logic [XLEN-1:0]   redirect_target;
  logic [XLEN-1:0]   fill_base;
  logic [XLEN-1:0]   pc_step;
  logic [XLEN-1:0]   fetch_pc;
  logic              comp_head;
  logic              req;
  logic              clear_raw;
  logic              head_comp_out;
  logic              accept;
  logic              skid_in_ready;
  logic              skid_valid;
  type_fetch2dec_s   skid_in;
  type_fetch2dec_s   skid_out;

`ifdef FETCH_COMP_EN
  assign comp_head           = head_is_comp(bus.pref_head_i);
  assign bus.pref_misalign_o = pc_ff[1];
  assign redirect_target     = {bus.redirect_pc_i[XLEN-1:1], 1'b0};
`else
  assign comp_head           = 1'b0;
  assign bus.pref_misalign_o = 1'b0;
  assign redirect_target     = {bus.redirect_pc_i[XLEN-1:2], 2'b00};
`endif

  // Fills push whole words, so a misaligned PC is fetched from its word base.
  assign fill_base = {pc_ff[XLEN-1:2], 2'b00};
  assign pc_step   = comp_head ? XLEN'(2) : XLEN'(4);

  // NOTE: every output of this block gets a default before the case so no
  // path leaves one unassigned, which would infer a latch.
  always_comb begin
    req           = 1'b0;
    clear_raw     = 1'b0;
    fetch_pc      = pc_ff;
    head_comp_out = 1'b0;
    case (state)
      FLUSH: clear_raw = 1'b1;
      FILL0: begin
        req      = 1'b1;
        fetch_pc = fill_base;
      end
      FILL1: begin
        req      = 1'b1;
        fetch_pc = fill_base + XLEN'(4);
      end
      RUN: begin
        req           = skid_in_ready;
        head_comp_out = comp_head;
      end
      default: ;
    endcase
  end

  // A redirect wins over any ack arriving in the same cycle.
  assign accept = (state == RUN) && req && bus.pref_ack_i && !bus.redirect_valid_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FLUSH;
      pc_ff <= RESET_PC;
    end else if (bus.redirect_valid_i) begin
      state <= FLUSH;
      pc_ff <= redirect_target;
    end else begin
      case (state)
        FLUSH: state <= FILL0;
        FILL0: if (bus.pref_ack_i) state <= FILL1;
        FILL1: if (bus.pref_ack_i) state <= RUN;
        RUN:   if (accept) pc_ff <= pc_ff + pc_step;
        default: state <= FLUSH;
      endcase
    end
  end

  assign skid_in = '{instr: bus.pref_instr_i, pc: pc_ff, is_comp: comp_head, valid: 1'b1};

  fetch_skid_buf #(
    .T         (type_fetch2dec_s),
    .RESET_VAL (SKID_RESET)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.redirect_valid_i),
    .in_valid  (accept),
    .in_data   (skid_in),
    .in_ready  (skid_in_ready),
    .out_valid (skid_valid),
    .out_ready (bus.dec_ready_i),
    .out_data  (skid_out)
  );

  assign bus.pref_pc_o        = fetch_pc;
  assign bus.pref_instr_req_o = req;
  assign bus.pref_is_comp_o   = head_comp_out;
  // Reset holds the FSM in FLUSH; keep the clear pulse off until reset lifts.
  assign bus.pref_clear_o     = clear_raw && reset;

  assign bus.dec_valid_o   = skid_valid && skid_out.valid;
  assign bus.dec_instr_o   = bus.dec_valid_o ? skid_out.instr : NOP_INSTR;
  assign bus.dec_pc_o      = skid_out.pc;
  assign bus.dec_is_comp_o = bus.dec_valid_o && skid_out.is_comp;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer; expectations follow FETCH_COMP_EN.
module tb_fetch_pc_sequencer;
  import fetch_pc_sequencer_pkg::*;

`ifdef FETCH_COMP_EN
  localparam bit COMP = 1'b1;
`else
  localparam bit COMP = 1'b0;
`endif

  localparam logic [31:0] RP   = 32'h8000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] I_A  = 32'h0010_0093;
  localparam logic [31:0] I_B  = 32'h0020_0113;
  localparam logic [31:0] I_C  = 32'h0030_0193;
  localparam logic [31:0] I_D  = 32'h0040_0213;
  localparam logic [31:0] I_E  = 32'h0050_0293;
  localparam logic [15:0] H16  = 16'h4501;
  // Redirect to 0x8000_0006: bit1 survives only with compressed support.
  localparam logic [31:0] TGT  = COMP ? 32'h8000_0006 : 32'h8000_0004;
  localparam logic        MIS  = COMP;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_pc_sequencer_if #(.XLEN(32)) bus ();

  fetch_pc_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic redir, input logic [31:0] rpc, input logic ack,
                       input logic [31:0] instr, input logic [15:0] head, input logic ready);
    @(negedge clk);
    bus.redirect_valid_i = redir;
    bus.redirect_pc_i    = rpc;
    bus.pref_ack_i       = ack;
    bus.pref_instr_i     = instr;
    bus.pref_head_i      = head;
    bus.dec_ready_i      = ready;
    #1;
  endtask

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] instr;
    logic [15:0] head;
    logic        ready;
    logic        e_clear;
    logic        e_req;
    logic [31:0] e_ppc;
    logic        e_mis;
    logic        e_pcomp;
    logic        e_valid;
    logic [31:0] e_dinstr;
    logic        chk_dpc;
    logic [31:0] e_dpc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic redir, input logic [31:0] rpc, input logic ack, input logic [31:0] instr,
    input logic [15:0] head, input logic ready, input logic e_clear, input logic e_req,
    input logic [31:0] e_ppc, input logic e_mis, input logic e_pcomp, input logic e_valid,
    input logic [31:0] e_dinstr, input logic chk_dpc, input logic [31:0] e_dpc);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.ack = ack; v.instr = instr; v.head = head;
    v.ready = ready; v.e_clear = e_clear; v.e_req = e_req; v.e_ppc = e_ppc;
    v.e_mis = e_mis; v.e_pcomp = e_pcomp; v.e_valid = e_valid; v.e_dinstr = e_dinstr;
    v.chk_dpc = chk_dpc; v.e_dpc = e_dpc;
    return v;
  endfunction

  int          clear_at;
  int          valid_at;
  int          clear_cnt;
  logic [31:0] first_pc;
  logic [31:0] wrap_pc;

  initial begin
    bus.redirect_valid_i = 1'b0;
    bus.redirect_pc_i    = '0;
    bus.pref_ack_i       = 1'b0;
    bus.pref_instr_i     = '0;
    bus.pref_head_i      = '0;
    bus.dec_ready_i      = 1'b1;

    //          redir rpc           ack instr head        rdy  clr req ppc          mis  pcmp vld dinstr chk dpc
    vecs.push_back(mk(0, 0,            0, 0,   I_A[15:0], 1,   1,  0,  RP,          0,   0,   0,  NOP,  1,  RP));
    vecs.push_back(mk(0, 0,            1, 0,   H16,       1,   0,  1,  RP,          0,   0,   0,  NOP,  1,  RP));
    vecs.push_back(mk(0, 0,            1, 0,   H16,       1,   0,  1,  RP + 4,      0,   0,   0,  NOP,  1,  RP));
    vecs.push_back(mk(0, 0,            1, I_A, I_A[15:0], 1,   0,  1,  RP,          0,   0,   0,  NOP,  1,  RP));
    vecs.push_back(mk(0, 0,            1, I_B, I_B[15:0], 1,   0,  1,  RP + 4,      0,   0,   1,  I_A,  1,  RP));
    vecs.push_back(mk(0, 0,            1, I_C, I_C[15:0], 0,   0,  0,  RP + 8,      0,   0,   1,  I_B,  1,  RP + 4));
    vecs.push_back(mk(0, 0,            0, 0,   I_C[15:0], 0,   0,  0,  RP + 8,      0,   0,   1,  I_B,  1,  RP + 4));
    vecs.push_back(mk(0, 0,            0, 0,   I_C[15:0], 0,   0,  0,  RP + 8,      0,   0,   1,  I_B,  1,  RP + 4));
    vecs.push_back(mk(0, 0,            1, I_C, I_C[15:0], 1,   0,  1,  RP + 8,      0,   0,   1,  I_B,  1,  RP + 4));
    vecs.push_back(mk(0, 0,            0, 0,   I_C[15:0], 1,   0,  1,  RP + 12,     0,   0,   1,  I_C,  1,  RP + 8));
    vecs.push_back(mk(0, 0,            0, 0,   I_C[15:0], 1,   0,  1,  RP + 12,     0,   0,   0,  NOP,  0,  0));
    vecs.push_back(mk(1, 32'h8000_0006, 1, I_D, I_D[15:0], 1,  0,  1,  RP + 12,     0,   0,   0,  NOP,  0,  0));
    vecs.push_back(mk(0, 0,            0, 0,   I_D[15:0], 1,   1,  0,  TGT,         MIS, 0,   0,  NOP,  0,  0));
    vecs.push_back(mk(0, 0,            1, 0,   H16,       1,   0,  1,  32'h8000_0004, MIS, 0, 0,  NOP,  0,  0));
    vecs.push_back(mk(0, 0,            1, 0,   H16,       1,   0,  1,  32'h8000_0008, MIS, 0, 0,  NOP,  0,  0));
    vecs.push_back(mk(0, 0,            1, I_E, I_E[15:0], 1,   0,  1,  TGT,         MIS, 0,   0,  NOP,  0,  0));
    vecs.push_back(mk(0, 0,            0, 0,   I_E[15:0], 0,   0,  0,  TGT + 4,     MIS, 0,   1,  I_E,  1,  TGT));
    vecs.push_back(mk(0, 0,            0, 0,   I_E[15:0], 1,   0,  1,  TGT + 4,     MIS, 0,   1,  I_E,  1,  TGT));
    vecs.push_back(mk(0, 0,            0, 0,   I_E[15:0], 1,   0,  1,  TGT + 4,     MIS, 0,   0,  NOP,  0,  0));

    // Reset state while reset is held low.
    #12;
    check("rst_req",    bus.pref_instr_req_o, 1'b0);
    check("rst_clear",  bus.pref_clear_o,     1'b0);
    check("rst_valid",  bus.dec_valid_o,      1'b0);
    check("rst_dinstr", bus.dec_instr_o,      NOP);
    check("rst_dpc",    bus.dec_pc_o,         RP);
    check("rst_ppc",    bus.pref_pc_o,        RP);
    @(posedge clk);
    #2 reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].redir, vecs[i].rpc, vecs[i].ack, vecs[i].instr, vecs[i].head, vecs[i].ready);
      check($sformatf("v%0d_clear", i),  bus.pref_clear_o,     vecs[i].e_clear);
      check($sformatf("v%0d_req", i),    bus.pref_instr_req_o, vecs[i].e_req);
      check($sformatf("v%0d_ppc", i),    bus.pref_pc_o,        vecs[i].e_ppc);
      check($sformatf("v%0d_mis", i),    bus.pref_misalign_o,  vecs[i].e_mis);
      check($sformatf("v%0d_pcomp", i),  bus.pref_is_comp_o,   vecs[i].e_pcomp);
      check($sformatf("v%0d_valid", i),  bus.dec_valid_o,      vecs[i].e_valid);
      check($sformatf("v%0d_dinstr", i), bus.dec_instr_o,      vecs[i].e_dinstr);
      check($sformatf("v%0d_dcomp", i),  bus.dec_is_comp_o,    1'b0);
      if (vecs[i].chk_dpc)
        check($sformatf("v%0d_dpc", i),  bus.dec_pc_o,         vecs[i].e_dpc);
    end

    // Mixed-length stream: 32-bit, 16-bit, 32-bit from 0x8000_0000.
    drive(1, RP, 0, 0, I_A[15:0], 1);
    drive(0, 0, 0, 0, I_A[15:0], 1);
    check("st_clear", bus.pref_clear_o, 1'b1);
    drive(0, 0, 1, 0, H16, 1);
    drive(0, 0, 1, 0, H16, 1);
    drive(0, 0, 1, I_A, I_A[15:0], 1);
    check("st1_ppc", bus.pref_pc_o, RP);
    check("st1_mis", bus.pref_misalign_o, 1'b0);
    drive(0, 0, 1, 32'h0000_4501, H16, 1);
    check("st2_ppc",   bus.pref_pc_o, RP + 4);
    check("st2_mis",   bus.pref_misalign_o, 1'b0);
    check("st2_pcomp", bus.pref_is_comp_o, COMP);
    check("st2_dpc",   bus.dec_pc_o, RP);
    drive(0, 0, 1, I_B, I_B[15:0], 1);
    check("st3_ppc",   bus.pref_pc_o, COMP ? RP + 6 : RP + 8);
    check("st3_mis",   bus.pref_misalign_o, MIS);
    check("st3_dpc",   bus.dec_pc_o, RP + 4);
    check("st3_dinstr", bus.dec_instr_o, 32'h0000_4501);
    check("st3_dcomp", bus.dec_is_comp_o, COMP);
    drive(0, 0, 0, 0, I_B[15:0], 1);
    check("st4_dpc",   bus.dec_pc_o, COMP ? RP + 6 : RP + 8);
    check("st4_dinstr", bus.dec_instr_o, I_B);
    check("st4_dcomp", bus.dec_is_comp_o, 1'b0);
    check("st4_ppc",   bus.pref_pc_o, COMP ? RP + 10 : RP + 12);

    // Redirect-to-decode latency with a single-cycle ack per fill, bounded.
    drive(1, 32'h8000_0040, 0, 0, I_A[15:0], 1);
    clear_at  = -1;
    valid_at  = -1;
    clear_cnt = 0;
    first_pc  = '0;
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 1, I_A, I_A[15:0], 1);
      if (bus.pref_clear_o) begin
        clear_cnt++;
        if (clear_at < 0) clear_at = i;
      end
      if (bus.dec_valid_o && valid_at < 0) begin
        valid_at = i;
        first_pc = bus.dec_pc_o;
      end
    end
    check("lat_clear_cycles", clear_cnt, 1);
    check("lat_cycles", 32'(valid_at - clear_at), 4);
    check("lat_first_pc", first_pc, 32'h8000_0040);

    // Redirect while filling restarts from the newer target.
    drive(1, 32'h8000_0200, 0, 0, I_A[15:0], 1);
    drive(0, 0, 0, 0, I_A[15:0], 1);
    check("rf_clear0", bus.pref_clear_o, 1'b1);
    drive(1, 32'h8000_0300, 1, 0, H16, 1);
    check("rf_fill_ppc", bus.pref_pc_o, 32'h8000_0200);
    drive(0, 0, 0, 0, H16, 1);
    check("rf_clear1", bus.pref_clear_o, 1'b1);
    check("rf_flush_ppc", bus.pref_pc_o, 32'h8000_0300);
    drive(0, 0, 1, 0, H16, 1);
    check("rf_clear_off", bus.pref_clear_o, 1'b0);
    check("rf_refill_ppc", bus.pref_pc_o, 32'h8000_0300);

    // PC wrap at the top of the address space.
    wrap_pc = COMP ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;
    drive(1, 32'hFFFF_FFFE, 0, 0, H16, 1);
    drive(0, 0, 0, 0, H16, 1);
    drive(0, 0, 1, 0, H16, 1);
    check("wr_fill0_ppc", bus.pref_pc_o, 32'hFFFF_FFFC);
    drive(0, 0, 1, 0, H16, 1);
    check("wr_fill1_ppc", bus.pref_pc_o, 32'h0000_0000);
    drive(0, 0, 1, 32'h0000_4501, H16, 1);
    check("wr_run_ppc", bus.pref_pc_o, wrap_pc);
    drive(0, 0, 0, 0, H16, 1);
    check("wr_next_ppc", bus.pref_pc_o, 32'h0000_0000);
    check("wr_dpc", bus.dec_pc_o, wrap_pc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
